branch_predictor: RTL
=====================

# branch_predictor

Dynamic conditional-branch predictor for the pipelined RV32I core. The fetch stage queries it each cycle with the fetch PC and gets a taken/not-taken guess plus a target. The execute stage trains it with the resolved outcome from the branch comparator (`br_en`) and the computed target. It holds a 2-bit-counter pattern history table (PHT), a tagged branch target buffer (BTB) and performance counters.

## Interface
Parameters:
- `IDX_BITS`, 6: log2 of PHT/BTB entries (64).
- `GHR_BITS`, 6: global history length. Used only when gshare is compiled in. Must be ≤ `IDX_BITS`.

Ports:
- `clk` in 1: clock, all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `pred_pc` in 32: fetch PC.
- `pred_taken` out 1: predict taken. Combinational from current state.
- `pred_target` out 32: BTB target for `pred_pc`.
- `pred_hit` out 1: BTB valid and tag match.
- `pred_idx` out IDX_BITS: PHT index used. Fetch carries it down the pipe to `upd_idx`.
- `upd_valid` in 1: a conditional branch resolved this cycle in EX.
- `upd_pc` in 32: PC of the resolved branch.
- `upd_idx` in IDX_BITS: `pred_idx` captured when the branch was fetched.
- `upd_br_en` in 1: actual outcome from the comparator.
- `upd_target` in 32: computed taken target.
- `upd_pred_taken` in 1: `pred_taken` the branch was fetched with.
- `perf_branches` out 32: resolved-branch count.
- `perf_mispred` out 32: misprediction count.

## Operation
- PHT: 2^IDX_BITS 2-bit saturating counters.
  - Encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Counter MSB is the direction.
- BTB: 2^IDX_BITS entries of {valid, tag = pc[31:IDX_BITS+2], target[31:0]}.
  - Always indexed by `pc[IDX_BITS+1:2]`.
- Predict path (pure combinational; no state change):
  - `pred_idx` = `pred_pc[IDX_BITS+1:2]`, or the gshare hash (see Configuration).
  - `pred_hit` = BTB valid && tag match.
  - `pred_taken` = PHT[`pred_idx`][1] && `pred_hit`. Taken is never predicted without a target.
  - `pred_target` = BTB target, driven regardless of hit.
- Update when `upd_valid`:
  - PHT[`upd_idx`]: increment if `upd_br_en`, else decrement, saturating at 11/00.
  - If `upd_br_en`: BTB entry at `upd_pc` index gets valid=1, tag and target from `upd_pc`/`upd_target`, overwriting any alias.
  - Not-taken updates never touch the BTB.
  - `perf_branches` += 1.
  - `perf_mispred` += 1 if `upd_pred_taken != upd_br_en`.
- Perf counters are modulo 2^32 and wrap silently.
- When `upd_valid`=0 all state holds.
- Reset:
  - PHT all 01, BTB valid all 0, GHR 0, perf counters 0.
  - Outputs after reset: `pred_taken`=0, `pred_hit`=0, `perf_*`=0.
  - `pred_target` is don't-care until written; the implementation clears it to 0.
- Reset asserted mid-operation overrides a coincident update; nothing from that cycle is retained.

## Timing
- Predict latency 0: outputs are valid in the same cycle as `pred_pc`.
- Update latency 1: the new state is visible to predictions on the cycle after `upd_valid`.
- Simultaneous predict and update to the same index: the prediction sees the old value. No write-through bypass.
- One update per cycle maximum. There is no back-pressure: `upd_valid` is accepted unconditionally.

## Configuration
- `BP_GSHARE_EN` defined:
  - A `GHR_BITS` global history register shifts in `upd_br_en` at the LSB on every `upd_valid`.
  - `pred_idx` = `pred_pc[IDX_BITS+1:2]` XOR zero-extended GHR.
  - GHR resets to 0.
  - BTB indexing is unchanged.
- `BP_GSHARE_EN` undefined:
  - No GHR is built.
  - `pred_idx` = `pred_pc[IDX_BITS+1:2]`.

## Test plan
- Post-reset query, `pred_pc`=0x60: `pred_taken`=0, `pred_hit`=0, `pred_idx`=0x18, `perf_*`=0.
- Taken training, `upd_pc`=0x60, `upd_idx`=0x18, `upd_br_en`=1, `upd_target`=0x40, `upd_pred_taken`=0, one cycle:
  - Next cycle, query 0x60 → `pred_hit`=1, `pred_target`=0x40, `pred_taken`=1.
  - `perf_branches`=1, `perf_mispred`=1.
- Saturation: four further taken updates at idx 0x18, then one not-taken → still predicts taken (11→10). A second not-taken → `pred_taken`=0 (01).
- BTB alias: train taken at 0x60, then taken at 0x1060 (same index, different tag) → query 0x60 gives `pred_hit`=0, `pred_taken`=0. Query 0x1060 gives `pred_hit`=1.
- Same-cycle conflict: update idx 0x18 from 01 to 10 while querying 0x60 → that cycle `pred_taken`=0, next cycle 1. Assert `rst` together with an update → all reset values and `perf_branches`=0.
- Gshare only (`BP_GSHARE_EN` defined): after taken, taken, not-taken updates (GHR=0b110), query 0x60 → `pred_idx`=0x18^0x06=0x1E.

Source files
------------

// File: rtl/branch_predictor.sv
// Branch predictor: 2-bit counter PHT, tagged BTB and performance counters.
// Optional gshare indexing is compiled in when BP_GSHARE_EN is defined.
module branch_predictor #(
    parameter int IDX_BITS = 6,
    parameter int GHR_BITS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         pred_pc,
    output logic                pred_taken,
    output logic [31:0]         pred_target,
    output logic                pred_hit,
    output logic [IDX_BITS-1:0] pred_idx,
    input  logic                upd_valid,
    input  logic [31:0]         upd_pc,
    input  logic [IDX_BITS-1:0] upd_idx,
    input  logic                upd_br_en,
    input  logic [31:0]         upd_target,
    input  logic                upd_pred_taken,
    output logic [31:0]         perf_branches,
    output logic [31:0]         perf_mispred
);

    localparam int ENTRIES  = 1 << IDX_BITS;
    localparam int TAG_BITS = 30 - IDX_BITS;

    logic [1:0]          pht_r        [ENTRIES];
    logic                btb_valid_r  [ENTRIES];
    logic [TAG_BITS-1:0] btb_tag_r    [ENTRIES];
    logic [31:0]         btb_target_r [ENTRIES];
    logic [31:0]         perf_branches_r;
    logic [31:0]         perf_mispred_r;

    logic [IDX_BITS-1:0] pred_btb_idx_s;
    logic [TAG_BITS-1:0] pred_tag_s;
    logic [IDX_BITS-1:0] pred_idx_s;
    logic                pred_hit_s;
    logic [IDX_BITS-1:0] upd_btb_idx_s;
    logic [TAG_BITS-1:0] upd_tag_s;
    logic                unused_s;

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic logic [1:0] pht_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (ctr == 2'b11) ? 2'b11 : ctr + 2'd1;
        end else begin
            nxt = (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
        end
        return nxt;
    endfunction

    assign pred_btb_idx_s = pred_pc[IDX_BITS+1:2];
    assign pred_tag_s     = pred_pc[31:IDX_BITS+2];
    assign upd_btb_idx_s  = upd_pc[IDX_BITS+1:2];
    assign upd_tag_s      = upd_pc[31:IDX_BITS+2];
    assign unused_s       = ^{pred_pc[1:0], upd_pc[1:0]};

`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0] ghr_r;
    logic [IDX_BITS-1:0] ghr_ext_s;

    // Zero-extend the history to the index width before hashing.
    always_comb begin
        ghr_ext_s                 = '0;
        ghr_ext_s[GHR_BITS-1:0]   = ghr_r;
    end

    assign pred_idx_s = pred_btb_idx_s ^ ghr_ext_s;

    // Global history shifts in each resolved outcome at the LSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_r <= '0;
        end else if (upd_valid) begin
            ghr_r <= {ghr_r[GHR_BITS-2:0], upd_br_en};
        end else begin
            ghr_r <= ghr_r;
        end
    end
`else
    logic [31:0] unused_ghr_s;

    assign unused_ghr_s = 32'(GHR_BITS);
    assign pred_idx_s   = pred_btb_idx_s;
`endif

    // Prediction is purely combinational and never sees a same-cycle update.
    always_comb begin
        pred_hit_s = btb_valid_r[pred_btb_idx_s] && (btb_tag_r[pred_btb_idx_s] == pred_tag_s);
    end

    assign pred_idx    = pred_idx_s;
    assign pred_hit    = pred_hit_s;
    assign pred_target = btb_target_r[pred_btb_idx_s];
    assign pred_taken  = pht_r[pred_idx_s][1] && pred_hit_s;

    // Direction counters train on every resolved branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pht_r[i] <= 2'b01;
            end
        end else if (upd_valid) begin
            pht_r[upd_idx] <= pht_step(pht_r[upd_idx], upd_br_en);
        end else begin
            pht_r[upd_idx] <= pht_r[upd_idx];
        end
    end

    // Only taken branches allocate into the BTB, replacing any alias.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_valid_r[i]  <= 1'b0;
                btb_tag_r[i]    <= '0;
                btb_target_r[i] <= 32'd0;
            end
        end else if (upd_valid && upd_br_en) begin
            btb_valid_r[upd_btb_idx_s]  <= 1'b1;
            btb_tag_r[upd_btb_idx_s]    <= upd_tag_s;
            btb_target_r[upd_btb_idx_s] <= upd_target;
        end else begin
            btb_valid_r[upd_btb_idx_s]  <= btb_valid_r[upd_btb_idx_s];
        end
    end

    // Performance counters wrap modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_branches_r <= 32'd0;
            perf_mispred_r  <= 32'd0;
        end else if (upd_valid) begin
            perf_branches_r <= perf_branches_r + 32'd1;
            perf_mispred_r  <= perf_mispred_r + ((upd_pred_taken != upd_br_en) ? 32'd1 : 32'd0);
        end else begin
            perf_branches_r <= perf_branches_r;
            perf_mispred_r  <= perf_mispred_r;
        end
    end

    assign perf_branches = perf_branches_r;
    assign perf_mispred  = perf_mispred_r;

endmodule
